// File: rtl/rob_commit_pkg.sv
// rtl/rob_commit_pkg.sv - shared widths, sizes and tag/index mapping for the reorder buffer
package rob_commit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_WIDTH  = 5;
    localparam int TAG_WIDTH  = 5;
    localparam int ROB_SIZE   = 16;
    localparam int EMPTY_TAG  = 0;
    localparam int EMPTY_REG  = 0;

    // Tag 0 is reserved for "no tag", so entry i is named by tag i+1.
    function automatic int tag_to_idx(input int tag);
        return tag - 1;
    endfunction

    function automatic int idx_to_tag(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - reorder buffer: tag allocation, CDB writeback, in-order commit, mispredict flush
// Optional operand lookup ports are built when ROB_OPERAND_QUERY_EN is defined.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int DEPTH  = ROB_SIZE,
    parameter int TAG_W  = TAG_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int REG_W  = REG_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              rob_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [31:0]       cdb_target,
    output logic              if_commit,
    output logic [REG_W-1:0]  pos_commit,
    output logic [DATA_W-1:0] data_commit,
    output logic [TAG_W-1:0]  tag_commit,
    output logic              clear,
    output logic [31:0]       redirect_pc
`ifdef ROB_OPERAND_QUERY_EN
    ,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic [DATA_W-1:0] q1_data,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q2_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic              ent_busy   [DEPTH];
    logic              ent_ready  [DEPTH];
    logic              ent_mis    [DEPTH];
    logic [REG_W-1:0]  ent_rd     [DEPTH];
    logic [DATA_W-1:0] ent_data   [DEPTH];
    logic [31:0]       ent_target [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic [PTR_W-1:0]  wb_idx;
    logic              wb_tag_ok;
    logic              do_alloc;
    logic              do_wb;
    logic              do_commit;

    assign alloc_tag = TAG_W'(idx_to_tag(int'(tail)));
    assign rob_full  = (count == (PTR_W+1)'(DEPTH));

    assign wb_idx    = PTR_W'(tag_to_idx(int'(cdb_tag)));
    assign wb_tag_ok = (int'(cdb_tag) != EMPTY_TAG) && (int'(cdb_tag) <= DEPTH);
    assign do_alloc  = alloc_valid && !rob_full && !clear;
    assign do_wb     = cdb_valid && !clear && wb_tag_ok && ent_busy[wb_idx];
    assign do_commit = (count != '0) && ent_busy[head] && ent_ready[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            if_commit   <= 1'b0;
            clear       <= 1'b0;
            pos_commit  <= '0;
            data_commit <= '0;
            tag_commit  <= '0;
            redirect_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_busy[i]  <= 1'b0;
                ent_ready[i] <= 1'b0;
            end
        end else if (!rdy) begin
            if_commit <= 1'b0;
            clear     <= 1'b0;
        end else begin
            if_commit <= 1'b0;
            clear     <= 1'b0;
            if (do_wb) begin
                ent_ready[wb_idx]  <= 1'b1;
                ent_data[wb_idx]   <= cdb_data;
                ent_mis[wb_idx]    <= cdb_mispredict;
                ent_target[wb_idx] <= cdb_target;
            end
            if (do_alloc) begin
                ent_busy[tail]  <= 1'b1;
                ent_ready[tail] <= 1'b0;
                ent_rd[tail]    <= alloc_rd;
                ent_mis[tail]   <= 1'b0;
                tail            <= tail + PTR_W'(1);
            end
            if (do_commit) begin
                pos_commit  <= ent_rd[head];
                data_commit <= ent_data[head];
                tag_commit  <= TAG_W'(idx_to_tag(int'(head)));
                if_commit   <= (int'(ent_rd[head]) != EMPTY_REG);
            end
            // A retiring mispredict wipes everything, overriding this edge's alloc/writeback.
            if (do_commit && ent_mis[head]) begin
                clear       <= 1'b1;
                redirect_pc <= ent_target[head];
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_busy[i]  <= 1'b0;
                    ent_ready[i] <= 1'b0;
                end
            end else begin
                if (do_commit) begin
                    ent_busy[head]  <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + PTR_W'(1);
                end
                count <= count + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_commit);
            end
        end
    end

`ifdef ROB_OPERAND_QUERY_EN
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
        logic [PTR_W-1:0] idx;
        logic             tag_ok;
        idx    = PTR_W'(tag_to_idx(int'(tag)));
        tag_ok = (int'(tag) != EMPTY_TAG) && (int'(tag) <= DEPTH);
        if (tag_ok && ent_busy[idx] && ent_ready[idx])
            return {1'b1, ent_data[idx]};
        else if (tag_ok && cdb_valid && (cdb_tag == tag))
            return {1'b1, cdb_data};
        return '0;
    endfunction

    assign {q1_ready, q1_data} = lookup(q1_tag);
    assign {q2_ready, q2_data} = lookup(q2_tag);
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed and random checks of rob_commit against a queue-based reference model
module tb_rob_commit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = '0;
    logic [4:0]  alloc_tag;
    logic        rob_full;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        cdb_mispredict = 1'b0;
    logic [31:0] cdb_target = '0;
    logic        if_commit;
    logic [4:0]  pos_commit;
    logic [31:0] data_commit;
    logic [4:0]  tag_commit;
    logic        clear;
    logic [31:0] redirect_pc;

    rob_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_tag(alloc_tag), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
        .tag_commit(tag_commit), .clear(clear), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions in program order.
    typedef struct {
        int          rd;
        bit          done;
        logic [31:0] data;
        bit          misp;
        logic [31:0] target;
        int          tag;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    bit          e_com, e_if, e_clear;
    int          e_pos, e_tag;
    logic [31:0] e_data, e_pc;

    task automatic model_reset();
        q.delete();
        m_tail  = 0;
        e_com   = 0;
        e_if    = 0;
        e_clear = 0;
    endtask

    task automatic model_update(input bit r, input bit av, input int ard, input bit cv,
                                input int ctag, input logic [31:0] cd, input bit cm,
                                input logic [31:0] ct);
        bit   flushing, full, commit;
        ent_t h;
        flushing = e_clear;
        full     = (q.size() == DEPTH);
        e_com    = 0;
        e_if     = 0;
        e_clear  = 0;
        if (!r) return;
        commit = (q.size() > 0) && q[0].done;
        if (commit) h = q[0];
        if (cv && !flushing)
            foreach (q[i])
                if (q[i].tag == ctag) begin
                    q[i].done   = 1;
                    q[i].data   = cd;
                    q[i].misp   = cm;
                    q[i].target = ct;
                end
        if (av && !full && !flushing) begin
            q.push_back('{rd: ard, done: 0, data: '0, misp: 0, target: '0, tag: m_tail + 1});
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (commit) begin
            e_com  = 1;
            e_pos  = h.rd;
            e_data = h.data;
            e_tag  = h.tag;
            e_if   = (h.rd != 0);
            if (h.misp) begin
                e_clear = 1;
                e_pc    = h.target;
                q.delete();
                m_tail  = 0;
            end else begin
                void'(q.pop_front());
            end
        end
    endtask

    task automatic step(input bit r, input bit av, input int ard, input bit cv, input int ctag,
                        input logic [31:0] cd, input bit cm, input logic [31:0] ct);
        rdy            = r;
        alloc_valid    = av;
        alloc_rd       = 5'(ard);
        cdb_valid      = cv;
        cdb_tag        = 5'(ctag);
        cdb_data       = cd;
        cdb_mispredict = cm;
        cdb_target     = ct;
        @(negedge clk);
        check("alloc_tag", 64'(alloc_tag), 64'(m_tail + 1));
        check("rob_full", 64'(rob_full), 64'(q.size() == DEPTH));
        model_update(r, av, ard, cv, ctag, cd, cm, ct);
        @(posedge clk);
        #1;
        check("if_commit", 64'(if_commit), 64'(e_if));
        check("clear", 64'(clear), 64'(e_clear));
        if (e_com) begin
            check("pos_commit", 64'(pos_commit), 64'(e_pos));
            check("data_commit", 64'(data_commit), 64'(e_data));
            check("tag_commit", 64'(tag_commit), 64'(e_tag));
        end
        if (e_clear) check("redirect_pc", 64'(redirect_pc), 64'(e_pc));
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int rd);
        step(1, 1, rd, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input int tag, input logic [31:0] d, input bit m, input logic [31:0] t);
        step(1, 0, 0, 1, tag, d, m, t);
    endtask

    task automatic do_reset();
        rst = 1;
        rdy = 1;
        alloc_valid = 0;
        cdb_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check("rst_alloc_tag", 64'(alloc_tag), 64'd1);
        check("rst_rob_full", 64'(rob_full), 64'd0);
        check("rst_if_commit", 64'(if_commit), 64'd0);
        check("rst_clear", 64'(clear), 64'd0);
        check("rst_outputs", {27'(pos_commit), 5'(tag_commit), data_commit}, 64'd0);
        check("rst_redirect", 64'(redirect_pc), 64'd0);
    endtask

    initial begin
        // tags handed out in sequence
        do_reset();
        repeat (3) alloc(3);
        check("alloc_seq", 64'(alloc_tag), 64'd4);

        // out-of-order completion, in-order commit
        do_reset();
        alloc(5);
        alloc(6);
        wb(2, 32'hBB, 0, 0);
        wb(1, 32'hAA, 0, 0);
        idle();
        check("inorder_first", 64'(data_commit), 64'hAA);
        idle();
        check("inorder_second", 64'(data_commit), 64'hBB);
        idle();

        // full, refused allocation, wrap-around
        do_reset();
        repeat (DEPTH) alloc(1);
        check("full_flag", 64'(rob_full), 64'd1);
        alloc(2);
        wb(1, 32'h11, 0, 0);
        alloc(2);
        alloc(3);
        repeat (2) idle();

        // rd=0 retires silently
        do_reset();
        alloc(0);
        wb(1, 32'h55, 0, 0);
        idle();
        idle();

        // mispredict flush
        do_reset();
        repeat (4) alloc(7);
        wb(2, 32'h22, 1, 32'h1000);
        wb(1, 32'h11, 0, 0);
        idle();
        idle();
        check("flush_clear", 64'(clear), 64'd1);
        check("flush_pc", 64'(redirect_pc), 64'h1000);
        step(1, 1, 4, 1, 3, 32'h33, 0, 0);
        idle();

        // rdy freeze
        do_reset();
        alloc(9);
        wb(1, 32'h99, 0, 0);
        repeat (3) step(0, 1, 4, 0, 0, 0, 0, 0);
        idle();
        idle();

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          r, av, cv, cm;
            int          ctag;
            r    = ($urandom_range(0, 9) != 0);
            av   = ($urandom_range(0, 9) < 6);
            cv   = ($urandom_range(0, 9) < 7);
            cm   = ($urandom_range(0, 39) == 0);
            ctag = $urandom_range(0, 31);
            if (q.size() > 0 && $urandom_range(0, 9) != 0)
                ctag = q[$urandom_range(0, q.size() - 1)].tag;
            step(r, av, $urandom_range(0, 7), cv, ctag, $urandom, cm, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
